// File: rtl/hex_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_driver
// Description : Time-multiplexed 4-digit 7-segment driver with a frame-aligned
//               shadow register and a blank guard cycle at each slot start.
//               Optional leading-zero blanking when HEXSCAN_LZB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_driver #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int                 c_CNT_W   = $clog2(PRESCALE);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PRESCALE - 1);

    localparam logic [0:0] c_PRIME = 1'b0;
    localparam logic [0:0] c_RUN   = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               w_load;
    logic               w_run;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_dig;
    logic [15:0]        r_shadow;
    logic [3:0]         w_nib;
    logic               w_slot_blank;
    logic               w_frame_wrap;

    assign w_frame_wrap = (r_cnt == c_CNT_MAX) && (r_dig == 2'd3);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_PRIME: w_state_nxt = c_RUN;
            c_RUN:   w_state_nxt = c_RUN;
            default: w_state_nxt = c_PRIME;
        endcase
    end

    // FSM: outputs. PRIME holds the counters at slot 0 while the first value
    // is captured, so the scan always starts from digit 0.
    always_comb begin
        w_load = 1'b0;
        w_run  = 1'b0;
        case (r_state)
            c_PRIME: begin
                w_load = 1'b1;
            end
            c_RUN: begin
                w_run  = 1'b1;
                w_load = w_frame_wrap;
            end
            default: begin
                w_load = 1'b0;
                w_run  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_dig <= 2'd0;
        end else if (w_run) begin
            if (r_cnt == c_CNT_MAX) begin
                r_cnt <= '0;
                r_dig <= r_dig + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Shadow only changes between frames, so a frame never mixes two values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= 16'h0000;
        end else if (w_load) begin
            r_shadow <= value;
        end
    end

    always_comb begin
        w_nib = r_shadow[3:0];
        case (r_dig)
            2'd0:    w_nib = r_shadow[3:0];
            2'd1:    w_nib = r_shadow[7:4];
            2'd2:    w_nib = r_shadow[11:8];
            2'd3:    w_nib = r_shadow[15:12];
            default: w_nib = r_shadow[3:0];
        endcase
    end

`ifdef HEXSCAN_LZB_EN
    logic w_lz_blank;

    // Digit k is a leading zero when it and every higher digit are zero
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_dig)
            2'd0:    w_lz_blank = 1'b0;
            2'd1:    w_lz_blank = (r_shadow[15:4] == 12'h000);
            2'd2:    w_lz_blank = (r_shadow[15:8] == 8'h00);
            2'd3:    w_lz_blank = (r_shadow[15:12] == 4'h0);
            default: w_lz_blank = 1'b0;
        endcase
    end

    assign w_slot_blank = (r_cnt == '0) || w_lz_blank;
`else
    assign w_slot_blank = (r_cnt == '0);
`endif

    function automatic logic [6:0] f_hex2seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Registered outputs, one cycle behind the counter state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_load;
            if (w_slot_blank) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
            end else begin
                an  <= ~(4'b0001 << r_dig);
                seg <= f_hex2seg(w_nib);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scan_driver
// Description : Directed vector bench for hex_scan_driver (PRESCALE 4 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_driver;

    typedef struct {
        logic [15:0] val;
        int          n;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        ft;
    } vec_t;

    localparam logic [6:0] c_BL = 7'b1111111;
    localparam logic [6:0] c_S0 = 7'b1000000;
    localparam logic [6:0] c_S1 = 7'b1111001;
    localparam logic [6:0] c_S2 = 7'b0100100;
    localparam logic [6:0] c_S3 = 7'b0110000;
    localparam logic [6:0] c_S4 = 7'b0011001;
    localparam logic [6:0] c_S5 = 7'b0010010;
    localparam logic [6:0] c_S7 = 7'b1111000;
    localparam logic [6:0] c_S8 = 7'b0000000;
    localparam logic [6:0] c_S9 = 7'b0010000;
    localparam logic [6:0] c_SA = 7'b0001000;
    localparam logic [6:0] c_SB = 7'b0000011;
    localparam logic [6:0] c_SC = 7'b1000110;
    localparam logic [6:0] c_SF = 7'b0001110;

`ifdef HEXSCAN_LZB_EN
    localparam logic [3:0] c_ZAN1 = 4'b1111;
    localparam logic [3:0] c_ZAN2 = 4'b1111;
    localparam logic [3:0] c_ZAN3 = 4'b1111;
    localparam logic [6:0] c_ZSEG = c_BL;
`else
    localparam logic [3:0] c_ZAN1 = 4'b1101;
    localparam logic [3:0] c_ZAN2 = 4'b1011;
    localparam logic [3:0] c_ZAN3 = 4'b0111;
    localparam logic [6:0] c_ZSEG = c_S0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reset_n2 = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [15:0] value2 = 16'h89AB;
    logic [6:0]  seg, seg2;
    logic [3:0]  an, an2;
    logic        frame_tick, frame_tick2;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    hex_scan_driver #(.PRESCALE(4)) u_dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    hex_scan_driver #(.PRESCALE(2)) u_dut2 (
        .clk        (clk),
        .reset_n    (reset_n2),
        .value      (value2),
        .seg        (seg2),
        .an         (an2),
        .frame_tick (frame_tick2)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_ft);
        chk({tag, " an"},  16'(an),         16'(e_an));
        chk({tag, " seg"}, 16'(seg),        16'(e_seg));
        chk({tag, " ft"},  16'(frame_tick), 16'(e_ft));
    endtask

    function automatic void add(input logic [15:0] v, input int n,
                                input logic [3:0] a, input logic [6:0] s, input logic f);
        vec_t r;
        r.val = v; r.n = n; r.an = a; r.seg = s; r.ft = f;
        tbl.push_back(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e2_an [8];
        logic [6:0] e2_seg[8];

        // 1234 frame, A5C3 captured on the wrap edge
        add(16'h1234, 1, 4'b1111, c_BL, 1'b1);
        add(16'h1234, 1, 4'b1111, c_BL, 1'b0);
        add(16'h1234, 3, 4'b1110, c_S4, 1'b0);
        add(16'h1234, 1, 4'b1111, c_BL, 1'b0);
        add(16'h1234, 3, 4'b1101, c_S3, 1'b0);
        add(16'h1234, 1, 4'b1111, c_BL, 1'b0);
        add(16'h1234, 3, 4'b1011, c_S2, 1'b0);
        add(16'h1234, 1, 4'b1111, c_BL, 1'b0);
        add(16'h1234, 2, 4'b0111, c_S1, 1'b0);
        add(16'hA5C3, 1, 4'b0111, c_S1, 1'b1);
        // A5C3 frame
        add(16'hA5C3, 1, 4'b1111, c_BL, 1'b0);
        add(16'hA5C3, 3, 4'b1110, c_S3, 1'b0);
        add(16'hA5C3, 1, 4'b1111, c_BL, 1'b0);
        add(16'hA5C3, 3, 4'b1101, c_SC, 1'b0);
        add(16'hA5C3, 1, 4'b1111, c_BL, 1'b0);
        add(16'hA5C3, 3, 4'b1011, c_S5, 1'b0);
        add(16'hA5C3, 1, 4'b1111, c_BL, 1'b0);
        add(16'hA5C3, 2, 4'b0111, c_SA, 1'b0);
        add(16'h1111, 1, 4'b0111, c_SA, 1'b1);
        // 1111 frame, value changes to 2222 mid-frame
        add(16'h1111, 1, 4'b1111, c_BL, 1'b0);
        add(16'h1111, 3, 4'b1110, c_S1, 1'b0);
        add(16'h1111, 1, 4'b1111, c_BL, 1'b0);
        add(16'h1111, 1, 4'b1101, c_S1, 1'b0);
        add(16'h2222, 2, 4'b1101, c_S1, 1'b0);
        add(16'h2222, 1, 4'b1111, c_BL, 1'b0);
        add(16'h2222, 3, 4'b1011, c_S1, 1'b0);
        add(16'h2222, 1, 4'b1111, c_BL, 1'b0);
        add(16'h2222, 2, 4'b0111, c_S1, 1'b0);
        add(16'h2222, 1, 4'b0111, c_S1, 1'b1);
        // 2222 frame
        add(16'h2222, 1, 4'b1111, c_BL, 1'b0);
        add(16'h2222, 3, 4'b1110, c_S2, 1'b0);
        add(16'h2222, 1, 4'b1111, c_BL, 1'b0);
        add(16'h2222, 3, 4'b1101, c_S2, 1'b0);
        add(16'h2222, 1, 4'b1111, c_BL, 1'b0);
        add(16'h2222, 3, 4'b1011, c_S2, 1'b0);
        add(16'h2222, 1, 4'b1111, c_BL, 1'b0);
        add(16'h2222, 2, 4'b0111, c_S2, 1'b0);
        add(16'h0007, 1, 4'b0111, c_S2, 1'b1);
        // 0007 frame: leading zeros
        add(16'h0007, 1, 4'b1111, c_BL,   1'b0);
        add(16'h0007, 3, 4'b1110, c_S7,   1'b0);
        add(16'h0007, 1, 4'b1111, c_BL,   1'b0);
        add(16'h0007, 3, c_ZAN1,  c_ZSEG, 1'b0);
        add(16'h0007, 1, 4'b1111, c_BL,   1'b0);
        add(16'h0007, 3, c_ZAN2,  c_ZSEG, 1'b0);
        add(16'h0007, 1, 4'b1111, c_BL,   1'b0);
        add(16'h0007, 2, c_ZAN3,  c_ZSEG, 1'b0);
        add(16'h0000, 1, c_ZAN3,  c_ZSEG, 1'b1);
        // 0000 frame up to the first lit cycle of digit 2
        add(16'h0000, 1, 4'b1111, c_BL,   1'b0);
        add(16'h0000, 3, 4'b1110, c_S0,   1'b0);
        add(16'h0000, 1, 4'b1111, c_BL,   1'b0);
        add(16'h0000, 3, c_ZAN1,  c_ZSEG, 1'b0);
        add(16'h0000, 1, 4'b1111, c_BL,   1'b0);
        add(16'h0000, 1, c_ZAN2,  c_ZSEG, 1'b0);

        // Reset held: outputs idle while value toggles
        for (int i = 0; i < 4; i++) begin
            value = 16'(i * 16'h1357 + 16'h0F0F);
            tick();
            chk_out($sformatf("rst%0d", i), 4'b1111, c_BL, 1'b0);
        end
        value   = 16'h1234;
        reset_n = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            value = tbl[r].val;
            for (int c = 0; c < tbl[r].n; c++) begin
                tick();
                chk_out($sformatf("row%0d.%0d", r, c), tbl[r].an, tbl[r].seg, tbl[r].ft);
            end
        end

        // Mid-frame reset during digit 2: blanking must not wait for a clock
        #2;
        reset_n = 1'b0;
        value   = 16'hBEEF;
        #1;
        chk_out("async_rst", 4'b1111, c_BL, 1'b0);
        tick();
        chk_out("rst_hold", 4'b1111, c_BL, 1'b0);
        reset_n = 1'b1;
        tick();
        chk_out("restart0", 4'b1111, c_BL, 1'b1);
        tick();
        chk_out("restart1", 4'b1111, c_BL, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("restart_d0_%0d", i), 4'b1110, c_SF, 1'b0);
        end
        tick();
        chk_out("restart_blank", 4'b1111, c_BL, 1'b0);

        // PRESCALE=2: blank/lit alternation, 8-cycle frame
        e2_an[0] = 4'b1111; e2_seg[0] = c_BL;
        e2_an[1] = 4'b1110; e2_seg[1] = c_SB;
        e2_an[2] = 4'b1111; e2_seg[2] = c_BL;
        e2_an[3] = 4'b1101; e2_seg[3] = c_SA;
        e2_an[4] = 4'b1111; e2_seg[4] = c_BL;
        e2_an[5] = 4'b1011; e2_seg[5] = c_S9;
        e2_an[6] = 4'b1111; e2_seg[6] = c_BL;
        e2_an[7] = 4'b0111; e2_seg[7] = c_S8;
        chk("p2 idle an", 16'(an2), 16'(4'b1111));
        reset_n2 = 1'b1;
        tick();
        chk("p2 prime ft",  16'(frame_tick2), 16'(1'b1));
        chk("p2 prime an",  16'(an2),         16'(4'b1111));
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk($sformatf("p2 k%0d an", k),  16'(an2),  16'(e2_an[(k-1)%8]));
            chk($sformatf("p2 k%0d seg", k), 16'(seg2), 16'(e2_seg[(k-1)%8]));
            chk($sformatf("p2 k%0d ft", k),  16'(frame_tick2), 16'((k % 8) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
